// File: rtl/mem_access_stage.sv
// MEM stage of the RV32 pipeline: issues loads/stores to a variable-latency
// data memory over a req/ack handshake, stalls upstream while an access is
// outstanding, resolves PC redirects and holds the MEM/WB boundary register.
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] read_data_2_mem,
  input  logic [DATA_W-1:0] aluresult_mem,
  input  logic              branch_mem,
  input  logic              zero_mem,
  input  logic              memwrite_mem,
  input  logic              memtoreg_mem,
  input  logic              regwrite_mem,
  input  logic              Jal_mem,
  input  logic              Jalr_mem,
  input  logic [4:0]        instruccion_117_mem,
  input  logic [DATA_W-1:0] result_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_o,
  output logic              pcsrc_o,
  output logic [DATA_W-1:0] pc_target_o,
  output logic              regwrite_wb,
  output logic              memtoreg_wb,
  output logic [DATA_W-1:0] read_data_wb,
  output logic [DATA_W-1:0] aluresult_wb,
  output logic [4:0]        instruccion_117_wb,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   lbuf_q;
  logic                abort_q;

  logic                dmem_req_q;
  logic                dmem_we_q;
  logic [DATA_W-1:0]   dmem_addr_q;
  logic [DATA_W-1:0]   dmem_wdata_q;
  logic                misalign_q;
  logic                bus_err_q;

  logic                regwrite_wb_q;
  logic                memtoreg_wb_q;
  logic [DATA_W-1:0]   read_data_wb_q;
  logic [DATA_W-1:0]   aluresult_wb_q;
  logic [4:0]          rd_wb_q;

  logic                mem_op;
  logic                aligned;
  logic                start_acc;
  logic                misal;
  logic                timeout;
  logic                wb_kill;
  logic [DATA_W-1:0]   wb_rdata_d;

  // Decode the current EX/MEM instruction and derive stall and redirect.
  always_comb begin
    mem_op      = memwrite_mem | memtoreg_mem;
    aligned     = (aluresult_mem[1:0] == 2'b00);
    start_acc   = (state_q == S_IDLE) & mem_op & aligned;
    misal       = (state_q == S_IDLE) & mem_op & ~aligned;
    timeout     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    stall_o     = start_acc | (state_q == S_WAIT);
    pcsrc_o     = (branch_mem & zero_mem) | Jal_mem | Jalr_mem;
    pc_target_o = Jalr_mem ? {aluresult_mem[DATA_W-1:1], 1'b0} : result_mem;
    // An aborted access or a misaligned op must never write the register file.
    wb_kill     = misal | ((state_q == S_DONE) & abort_q);
    wb_rdata_d  = ((state_q == S_DONE) & memtoreg_mem) ? lbuf_q : '0;
  end

  // Access FSM with its registered memory-bus and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lbuf_q       <= '0;
      abort_q      <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      misalign_q <= misal;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q   <= '0;
          abort_q <= 1'b0;
          if (start_acc) begin
            state_q      <= S_WAIT;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= memwrite_mem;
            dmem_addr_q  <= aluresult_mem;
            dmem_wdata_q <= read_data_2_mem;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion in the final allowed cycle still counts as success.
          if (dmem_ack) begin
            lbuf_q     <= dmem_rdata;
            dmem_req_q <= 1'b0;
            abort_q    <= 1'b0;
            state_q    <= S_DONE;
          end else if (timeout) begin
            lbuf_q     <= '0;
            dmem_req_q <= 1'b0;
            abort_q    <= 1'b1;
            bus_err_q  <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // MEM/WB boundary: load on free cycles, insert a bubble while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_wb_q  <= 1'b0;
      memtoreg_wb_q  <= 1'b0;
      read_data_wb_q <= '0;
      aluresult_wb_q <= '0;
      rd_wb_q        <= '0;
    end else if (!stall_o) begin
      regwrite_wb_q  <= regwrite_mem & ~wb_kill;
      memtoreg_wb_q  <= memtoreg_mem;
      read_data_wb_q <= wb_rdata_d;
      aluresult_wb_q <= aluresult_mem;
      rd_wb_q        <= instruccion_117_mem;
    end else begin
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
    end
  end

  assign dmem_req           = dmem_req_q;
  assign dmem_we            = dmem_we_q;
  assign dmem_addr          = dmem_addr_q;
  assign dmem_wdata         = dmem_wdata_q;
  assign misalign_err       = misalign_q;
  assign bus_err            = bus_err_q;
  assign regwrite_wb        = regwrite_wb_q;
  assign memtoreg_wb        = memtoreg_wb_q;
  assign read_data_wb       = read_data_wb_q;
  assign aluresult_wb       = aluresult_wb_q;
  assign instruccion_117_wb = rd_wb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results and memory
// requests are queued when an instruction is driven and checked when the
// stage releases it or raises dmem_req.
module tb_mem_access_stage;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] read_data_2_mem, aluresult_mem, result_mem;
  logic              branch_mem, zero_mem, memwrite_mem, memtoreg_mem;
  logic              regwrite_mem, Jal_mem, Jalr_mem;
  logic [4:0]        instruccion_117_mem;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic              stall_o, pcsrc_o;
  logic [DATA_W-1:0] pc_target_o;
  logic              regwrite_wb, memtoreg_wb;
  logic [DATA_W-1:0] read_data_wb, aluresult_wb;
  logic [4:0]        instruccion_117_wb;
  logic              misalign_err, bus_err;

  mem_access_stage #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_data_2_mem(read_data_2_mem), .aluresult_mem(aluresult_mem),
    .branch_mem(branch_mem), .zero_mem(zero_mem), .memwrite_mem(memwrite_mem),
    .memtoreg_mem(memtoreg_mem), .regwrite_mem(regwrite_mem),
    .Jal_mem(Jal_mem), .Jalr_mem(Jalr_mem),
    .instruccion_117_mem(instruccion_117_mem), .result_mem(result_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_o(stall_o), .pcsrc_o(pcsrc_o), .pc_target_o(pc_target_o),
    .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb),
    .read_data_wb(read_data_wb), .aluresult_wb(aluresult_wb),
    .instruccion_117_wb(instruccion_117_wb),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw, mtr, mw, br, z, jal, jalr;
    logic [4:0]  rd;
    logic [31:0] alu, wd, res;
  } ins_t;

  typedef struct packed {
    logic        rw, mtr;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr, wdata;
  } req_t;

  wb_t  wb_q  [$];
  req_t req_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input ins_t in);
    regwrite_mem        = in.rw;
    memtoreg_mem        = in.mtr;
    memwrite_mem        = in.mw;
    branch_mem          = in.br;
    zero_mem            = in.z;
    Jal_mem             = in.jal;
    Jalr_mem            = in.jalr;
    instruccion_117_mem = in.rd;
    aluresult_mem       = in.alu;
    read_data_2_mem     = in.wd;
    result_mem          = in.res;
  endtask

  function automatic ins_t nop();
    ins_t n;
    n = '0;
    return n;
  endfunction

  // Drive one instruction at posedge+1; ack_lat=0 means memory never answers.
  task automatic issue(input ins_t in, input int ack_lat, input logic [31:0] rdata);
    bit    memop, algn, acked;
    wb_t   ew, gw;
    req_t  er;
    int    nstall, nreq, nbus, exp_stall, exp_req;
    bit    done;
    logic  exp_pc;
    logic [31:0] exp_tgt;

    memop = in.mw | in.mtr;
    algn  = (in.alu[1:0] == 2'b00);
    acked = memop && algn && (ack_lat > 0) && (ack_lat <= TIMEOUT);
    ew.rw    = in.rw & ~(memop & ~algn) & ~(memop & algn & ~acked);
    ew.mtr   = in.mtr;
    ew.rd    = in.rd;
    ew.alu   = in.alu;
    ew.rdata = (in.mtr && acked) ? rdata : 32'h0;
    wb_q.push_back(ew);
    exp_req   = (memop && algn) ? (acked ? ack_lat : TIMEOUT) : 0;
    exp_stall = (memop && algn) ? exp_req + 1 : 0;
    if (memop && algn) begin
      er.we = in.mw; er.addr = in.alu; er.wdata = in.wd;
      req_q.push_back(er);
    end
    er = '0;

    drive(in);
    #1;
    exp_pc  = (in.br & in.z) | in.jal | in.jalr;
    exp_tgt = in.jalr ? {in.alu[31:1], 1'b0} : in.res;
    check("pcsrc", {31'b0, pcsrc_o}, {31'b0, exp_pc});
    check("pc_target", pc_target_o, exp_tgt);

    nstall = 0; nreq = 0; nbus = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (bus_err) nbus++;
      if (dmem_req) begin
        if (nreq == 0) begin
          if (req_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
          else er = req_q.pop_front();
        end
        check("dmem_we", {31'b0, dmem_we}, {31'b0, er.we});
        check("dmem_addr", dmem_addr, er.addr);
        if (er.we) check("dmem_wdata", dmem_wdata, er.wdata);
        nreq++;
        if (nreq == ack_lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
      if (stall_o) begin
        if (nstall >= 1) check("bubble_regwrite", {31'b0, regwrite_wb}, 32'd0);
        nstall++;
      end else begin
        done = 1;
      end
    end
    if (!done) check("release_bound", 32'd0, 32'd1);

    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    drive(nop());
    check("stall_cycles", nstall, exp_stall);
    check("req_cycles", nreq, exp_req);
    check("bus_err_pulses", nbus, (memop && algn && !acked) ? 1 : 0);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, memop & ~algn});
    check("req_after", {31'b0, dmem_req}, 32'd0);
    if (wb_q.size() == 0) begin
      check("wb_queue_empty", 32'd1, 32'd0);
    end else begin
      ew = wb_q.pop_front();
      gw.rw = regwrite_wb; gw.mtr = memtoreg_wb; gw.rd = instruccion_117_wb;
      gw.alu = aluresult_wb; gw.rdata = read_data_wb;
      check("regwrite_wb", {31'b0, gw.rw}, {31'b0, ew.rw});
      check("memtoreg_wb", {31'b0, gw.mtr}, {31'b0, ew.mtr});
      check("rd_wb", {27'b0, gw.rd}, {27'b0, ew.rd});
      check("aluresult_wb", gw.alu, ew.alu);
      check("read_data_wb", gw.rdata, ew.rdata);
    end
  endtask

  function automatic ins_t mk(input logic rw, mtr, mw, br, z, jal, jalr,
                              input logic [4:0] rd, input logic [31:0] alu, wd, res);
    ins_t t;
    t.rw = rw; t.mtr = mtr; t.mw = mw; t.br = br; t.z = z; t.jal = jal; t.jalr = jalr;
    t.rd = rd; t.alu = alu; t.wd = wd; t.res = res;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(nop());
    #1;
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_we", {31'b0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_regwrite_wb", {31'b0, regwrite_wb}, 32'd0);
    check("rst_read_data_wb", read_data_wb, 32'd0);
    check("rst_errs", {30'b0, misalign_err, bus_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add x5
    issue(mk(1,0,0,0,0,0,0, 5'd5, 32'h10, 32'h0, 32'h0), 0, 32'h0);
    // lw x3, 0x100, ack on third request cycle
    issue(mk(1,1,0,0,0,0,0, 5'd3, 32'h100, 32'h0, 32'h0), 3, 32'hDEADBEEF);
    // sw 0x1234 -> 0x204, ack on first WAIT cycle
    issue(mk(0,0,1,0,0,0,0, 5'd0, 32'h204, 32'h1234, 32'h0), 1, 32'h0);
    // misaligned lw at 0x102
    issue(mk(1,1,0,0,0,0,0, 5'd7, 32'h102, 32'h0, 32'h0), 0, 32'h0);
    // misaligned sw
    issue(mk(0,0,1,0,0,0,0, 5'd0, 32'h203, 32'hAAAA, 32'h0), 0, 32'h0);
    // lw 0x40, no ack -> timeout
    issue(mk(1,1,0,0,0,0,0, 5'd9, 32'h40, 32'h0, 32'h0), 0, 32'h0);
    // ack arrives on the very last allowed cycle
    issue(mk(1,1,0,0,0,0,0, 5'd11, 32'h44, 32'h0, 32'h0), TIMEOUT, 32'h0BADF00D);
    // beq taken, jalr, branch not taken, jal
    issue(mk(0,0,0,1,1,0,0, 5'd0, 32'h0, 32'h0, 32'h80), 0, 32'h0);
    issue(mk(1,0,0,0,0,0,1, 5'd1, 32'h91, 32'h0, 32'h55), 0, 32'h0);
    issue(mk(0,0,0,1,0,0,0, 5'd0, 32'h0, 32'h0, 32'hC0), 0, 32'h0);
    issue(mk(1,0,0,0,0,1,0, 5'd1, 32'h8, 32'h0, 32'h300), 0, 32'h0);
    // load then immediately another load with a random latency
    issue(mk(1,1,0,0,0,0,0, 5'd12, 32'h1F0, 32'h0, 32'h0), 1, 32'h13572468);
    issue(mk(1,1,0,0,0,0,0, 5'd13, 32'h1F4, 32'h0, 32'h0),
          $urandom_range(2, 6), 32'h2468ACE0);

    // Reset in the middle of WAIT, then a stale ack after release
    drive(mk(1,1,0,0,0,0,0, 5'd4, 32'h80, 32'h0, 32'h0));
    repeat (3) @(negedge clk);
    check("pre_rst_req", {31'b0, dmem_req}, 32'd1);
    #1;
    rst_n = 1'b0;
    drive(nop());
    #1;
    check("midrst_req", {31'b0, dmem_req}, 32'd0);
    check("midrst_stall", {31'b0, stall_o}, 32'd0);
    check("midrst_regwrite_wb", {31'b0, regwrite_wb}, 32'd0);
    check("midrst_aluresult_wb", aluresult_wb, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check("stale_ack_req", {31'b0, dmem_req}, 32'd0);
    check("stale_ack_stall", {31'b0, stall_o}, 32'd0);
    check("stale_ack_buserr", {31'b0, bus_err}, 32'd0);
    issue(mk(1,0,0,0,0,0,0, 5'd6, 32'h66, 32'h0, 32'h0), 0, 32'h0);

    check("wb_queue_drained", wb_q.size(), 32'd0);
    check("req_queue_drained", req_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
